// File: rtl/systolic_ctrl_if.sv
// Scheduler/buffer/array-facing signal bundle of the systolic array sequencer.
// SYSTOLIC_CTRL_WT_REUSE_EN adds the reuse_wt request line.
interface systolic_ctrl_if #(
    parameter int N_SIZE   = 32,
    parameter int MAX_ROWS = 256,
    parameter int AW       = $clog2(MAX_ROWS)
);
    localparam int WW = $clog2(N_SIZE);
    localparam int RW = $clog2(MAX_ROWS + 1);

    logic          start;
    logic [RW-1:0] tile_rows;
`ifdef SYSTOLIC_CTRL_WT_REUSE_EN
    logic          reuse_wt;
`endif
    logic          busy;
    logic          done;
    logic          w_rd_en;
    logic [WW-1:0] w_rd_addr;
    logic          a_rd_en;
    logic [AW-1:0] a_rd_addr;
    logic          wt_en;
    logic [WW-1:0] wt_row_sel;
    logic          valid_in;
    logic          c_wr_en;
    logic [AW-1:0] c_wr_addr;

`ifdef SYSTOLIC_CTRL_WT_REUSE_EN
    modport master (output start, tile_rows, reuse_wt,
                    input  busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
                           wt_en, wt_row_sel, valid_in, c_wr_en, c_wr_addr);
    modport slave  (input  start, tile_rows, reuse_wt,
                    output busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
                           wt_en, wt_row_sel, valid_in, c_wr_en, c_wr_addr);
`else
    modport master (output start, tile_rows,
                    input  busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
                           wt_en, wt_row_sel, valid_in, c_wr_en, c_wr_addr);
    modport slave  (input  start, tile_rows,
                    output busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
                           wt_en, wt_row_sel, valid_in, c_wr_en, c_wr_addr);
`endif
endinterface

// File: rtl/systolic_ctrl.sv
// Tile sequencer for a weight-stationary systolic array: weight load, A stream, drain.
// Optional weight reuse across tiles: define SYSTOLIC_CTRL_WT_REUSE_EN.
//
// state  | meaning
// IDLE   | waiting for start with nonzero tile_rows
// LOAD_W | issuing weight row reads 0..N_SIZE-1
// STREAM | issuing A row reads 0..rows_q-1
// DRAIN  | waiting for the last C write; done is pulsed in the final DRAIN cycle
module systolic_ctrl #(
    parameter int N_SIZE   = 32,
    parameter int MAX_ROWS = 256,
    parameter int OUT_LAT  = 64,
    parameter int AW       = $clog2(MAX_ROWS)
) (
    input logic          clk,
    input logic          rst_n,
    systolic_ctrl_if.slave bus
);
    localparam int WW = $clog2(N_SIZE);
    localparam int RW = $clog2(MAX_ROWS + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t             state, state_nx;
    logic [RW-1:0]      rows_q;
    logic [RW-1:0]      rows_in;
    logic [WW-1:0]      k_cnt;
    logic [RW-1:0]      r_cnt;
    logic [RW-1:0]      c_cnt;
    logic [OUT_LAT-1:0] dly;
    logic               start_ok;
    logic               reuse_go;
    logic               tile_end;

    assign rows_in  = (bus.tile_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : bus.tile_rows;
    assign start_ok = (state == IDLE) && bus.start && (bus.tile_rows != '0);
    assign tile_end = (state == DRAIN) && (c_cnt == rows_q);

`ifdef SYSTOLIC_CTRL_WT_REUSE_EN
    logic wt_loaded;
    assign reuse_go = bus.reuse_wt && wt_loaded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wt_loaded <= 1'b0;
        else if (state == LOAD_W && state_nx == STREAM)
            wt_loaded <= 1'b1;
    end
`else
    assign reuse_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rows_q         <= '0;
            k_cnt          <= '0;
            r_cnt          <= '0;
            c_cnt          <= '0;
            dly            <= '0;
            bus.wt_en      <= 1'b0;
            bus.wt_row_sel <= '0;
            bus.valid_in   <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok)
                rows_q <= rows_in;
            k_cnt <= (state == LOAD_W && state_nx == LOAD_W) ? k_cnt + WW'(1) : '0;
            r_cnt <= (state == STREAM && state_nx == STREAM) ? r_cnt + RW'(1) : '0;
            // C counter spans the whole tile; writes may begin while still streaming
            if (state == IDLE)
                c_cnt <= '0;
            else if (bus.c_wr_en)
                c_cnt <= c_cnt + RW'(1);
            dly          <= {dly[OUT_LAT-2:0], bus.valid_in};
            bus.wt_en    <= (state == LOAD_W);
            if (state == LOAD_W)
                bus.wt_row_sel <= k_cnt;
            bus.valid_in <= (state == STREAM);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = reuse_go ? STREAM : LOAD_W;
            LOAD_W:  if (k_cnt == WW'(N_SIZE - 1)) state_nx = STREAM;
            STREAM:  if (r_cnt == rows_q - RW'(1)) state_nx = DRAIN;
            DRAIN:   if (tile_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE) && !tile_end;
        bus.done      = tile_end;
        bus.w_rd_en   = (state == LOAD_W);
        bus.w_rd_addr = k_cnt;
        bus.a_rd_en   = (state == STREAM);
        bus.a_rd_addr = r_cnt[AW-1:0];
        bus.c_wr_en   = dly[OUT_LAT-1];
        bus.c_wr_addr = c_cnt[AW-1:0];
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-cycle comparison against a timeline model
// derived from the tile schedule (load, stream, fixed output latency, done).
module tb_systolic_ctrl;
    localparam int N  = 4;
    localparam int MR = 256;
    localparam int OL = 8;
    localparam int AW = 8;
    localparam int WW = 2;
    localparam int RW = 9;
    localparam int VW = 27;
`ifdef SYSTOLIC_CTRL_WT_REUSE_EN
    localparam bit REUSE_ON = 1'b1;
`else
    localparam bit REUSE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.N_SIZE(N), .MAX_ROWS(MR)) bus();
    systolic_ctrl #(.N_SIZE(N), .MAX_ROWS(MR), .OUT_LAT(OL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit wt_loaded_m = 1'b0;

    // addresses are only meaningful alongside their strobe
    function automatic logic [VW-1:0] observe();
        return {bus.busy, bus.done,
                bus.w_rd_en, bus.w_rd_en ? bus.w_rd_addr : WW'(0),
                bus.wt_en,   bus.wt_en   ? bus.wt_row_sel : WW'(0),
                bus.a_rd_en, bus.a_rd_en ? bus.a_rd_addr : AW'(0),
                bus.valid_in,
                bus.c_wr_en, bus.c_wr_en ? bus.c_wr_addr : AW'(0)};
    endfunction

    function automatic logic [VW-1:0] raw_outputs();
        return {bus.busy, bus.done, bus.w_rd_en, bus.w_rd_addr, bus.wt_en, bus.wt_row_sel,
                bus.a_rd_en, bus.a_rd_addr, bus.valid_in, bus.c_wr_en, bus.c_wr_addr};
    endfunction

    // c counts cycles after the start cycle; L weight-load cycles, R rows
    function automatic logic [VW-1:0] expect_at(int c, int L, int R);
        logic b, d, we, wt, ae, v, ce;
        logic [WW-1:0] wa, wr;
        logic [AW-1:0] aa, ca;
        we = (c >= 1) && (c <= L);
        wa = we ? WW'(c - 1) : WW'(0);
        wt = (L > 0) && (c >= 2) && (c <= L + 1);
        wr = wt ? WW'(c - 2) : WW'(0);
        ae = (c >= L + 1) && (c <= L + R);
        aa = ae ? AW'(c - L - 1) : AW'(0);
        v  = (c >= L + 2) && (c <= L + R + 1);
        ce = (c >= L + 2 + OL) && (c <= L + R + 1 + OL);
        ca = ce ? AW'(c - L - 2 - OL) : AW'(0);
        d  = (c == L + R + OL + 2);
        b  = (c >= 1) && (c <= L + R + OL + 1);
        return {b, d, we, wa, wt, wr, ae, aa, v, ce, ca};
    endfunction

    task automatic run_tile(input int rows, input bit reuse, input bit junk,
                            input bit start_at_done, input int abort_at, input string tag);
        int R, L, last;
        logic [VW-1:0] o, e;
        R    = (rows > MR) ? MR : rows;
        L    = (reuse && wt_loaded_m && REUSE_ON) ? 0 : N;
        last = L + R + OL + 2;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.tile_rows = RW'(rows);
`ifdef SYSTOLIC_CTRL_WT_REUSE_EN
        bus.reuse_wt  = reuse;
`endif
        o = observe();
        n_checks++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL %s start_cycle: got %h want 0", tag, o);
        end
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (junk && c < last && $urandom_range(0, 3) == 0) begin
                bus.start     = 1'b1;
                bus.tile_rows = RW'($urandom_range(1, MR));
            end
            if (start_at_done && c == last) begin
                bus.start     = 1'b1;
                bus.tile_rows = RW'(rows);
            end
            if (c == abort_at) begin
                bus.start = 1'b0;
                rst_n = 1'b0;
                #1;
                o = raw_outputs();
                n_checks++;
                if (o !== '0) begin
                    n_fail++;
                    $display("FAIL %s abort_outputs: got %h want 0", tag, o);
                end
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s abort_no_done: got done=%b busy=%b want 0 0",
                                 tag, bus.done, bus.busy);
                    end
                end
                rst_n = 1'b1;
                wt_loaded_m = 1'b0;
                return;
            end
            o = observe();
            e = expect_at(c, L, R);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h want %h", tag, c, o, e);
            end
        end
        if (L > 0) wt_loaded_m = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (raw_outputs() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", raw_outputs());
        end
        rst_n = 1'b1;
        wt_loaded_m = 1'b0;
    endtask

    task automatic test_basic();
        run_tile(3, 1'b0, 1'b0, 1'b0, 0, "basic");
    endtask

    task automatic test_reset_mid_stream();
        run_tile(8, 1'b0, 1'b0, 1'b0, N + 1 + 3, "mid_reset");
        run_tile(8, 1'b0, 1'b0, 1'b0, 0, "after_reset");
    endtask

    task automatic test_zero_rows();
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.tile_rows = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            n_checks++;
            if (observe() !== '0) begin
                n_fail++;
                $display("FAIL zero_rows cycle %0d: got %h want 0", i + 1, observe());
            end
        end
    endtask

    task automatic test_back_to_back();
        int r;
        r = $urandom_range(1, 20);
        run_tile(r, 1'b0, 1'b1, 1'b1, 0, "b2b_first");
        run_tile(r, 1'b0, 1'b0, 1'b0, 0, "b2b_second");
    endtask

    task automatic test_max_rows();
        run_tile(MR, 1'b0, 1'b0, 1'b0, 0, "max_rows");
        run_tile(300, 1'b0, 1'b0, 1'b0, 0, "clamp_rows");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            run_tile($urandom_range(1, 40), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0, "random");
    endtask

    task automatic test_wt_reuse();
        test_reset();
        run_tile(5, 1'b1, 1'b0, 1'b0, 0, "reuse_first");
        run_tile(5, 1'b1, 1'b0, 1'b0, 0, "reuse_second");
        run_tile(7, 1'b0, 1'b0, 1'b0, 0, "reuse_off");
        run_tile(2, 1'b1, 1'b1, 1'b0, 0, "reuse_again");
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.tile_rows = '0;
`ifdef SYSTOLIC_CTRL_WT_REUSE_EN
        bus.reuse_wt  = 1'b0;
`endif
        test_reset();
        test_basic();
        test_reset_mid_stream();
        test_zero_rows();
        test_back_to_back();
        test_max_rows();
        test_random();
        test_wt_reuse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
